saa1099_bus_arbiter: RTL and testbench
======================================

# saa1099_bus_arbiter

- Shares the single SAA1099 register-write port between two masters: the CPU I/O port and a register-stream source (tracker or playback FIFO).
- The CPU issues raw address and data writes. The stream source issues atomic register/value pairs.
- The block serialises all traffic into SAA1099 bus cycles with guaranteed strobe spacing.
- It keeps the chip's address latch coherent for the CPU when stream writes interleave with CPU writes.

## Interface
Parameters:
- WR_LOW, default 2: clk_sys cycles saa_wr_n/saa_cs_n held low per write (≥1).
- WR_HIGH, default 2: clk_sys cycles saa_wr_n held high after each write (≥1).

Ports:
- clk_sys  in  1  system clock, single clock domain.
- rst  in  1  synchronous, active-high reset.
- cpu_wr  in  1  one-cycle CPU write strobe.
- cpu_a0  in  1  1 = address write, 0 = data write.
- cpu_din  in  8  CPU write value.
- cpu_busy  out  1  CPU slot occupied.
- cpu_ovf  out  1  sticky flag: a CPU write arrived while cpu_busy = 1.
- fifo_valid  in  1  stream pair available.
- fifo_reg  in  5  target register.
- fifo_data  in  8  value.
- fifo_ready  out  1  pair accepted when fifo_valid & fifo_ready.
- saa_cs_n, saa_wr_n, saa_a0  out  1  SAA1099 bus.
- saa_din  out  8  SAA1099 data.
- active  out  1  transaction in progress (state ≠ IDLE).

## Operation
CPU slot (one entry):
- On cpu_wr with slot empty: capture {a0, din}.
- If a0 = 1, also set cpu_addr ← din[4:0] at capture.
- On cpu_wr with slot full: drop the write and set cpu_ovf.
- The slot clears on the grant cycle, so a new capture is possible during a transaction.

chip_addr / chip_addr_ok:
- Shadow of the SAA1099 address latch.
- chip_addr_ok = 0 after reset. It is set, with chip_addr updated, at the end of every address phase.

Grant (in IDLE only):
- With one requester pending, grant it.
- With both pending, grant the one not granted last. last_grant resets to stream, so the CPU wins the first tie.
- fifo_ready = IDLE & fifo_valid-independent & (slot empty | last_grant == CPU).

Transaction types:
- CPU address: ADDR phase with din, always issued, even if it equals chip_addr. Address writes clock the external envelope.
- CPU data: if !chip_addr_ok or chip_addr ≠ cpu_addr, run ADDR phase with cpu_addr first; then DATA phase with din.
- Stream pair: ADDR phase with fifo_reg, skipped if chip_addr_ok & chip_addr == fifo_reg; then DATA phase with fifo_data.
- Known side effect: a restoring ADDR write of 0x18/0x19 clocks an externally clocked envelope once.

FSM states: IDLE → ADDR_LO → ADDR_HI → (DATA_LO → DATA_HI) → IDLE.
- *_LO: saa_cs_n = 0, saa_wr_n = 0 for WR_LOW cycles.
- *_HI: saa_cs_n = 1, saa_wr_n = 1 for WR_HIGH cycles.
- saa_a0 (1 in ADDR, 0 in DATA) and saa_din are stable across the LO and HI of each phase.
- ADDR_HI goes to DATA_LO for data transactions and to IDLE for CPU address transactions.
- For data transactions with the address skipped, IDLE goes directly to DATA_LO.

## Timing
- All outputs are registered.
- Reset values: saa_cs_n = 1, saa_wr_n = 1, saa_a0 = 0, saa_din = 0, cpu_busy = 0, cpu_ovf = 0, fifo_ready = 0, active = 0.
- Internal reset values: slot empty, chip_addr_ok = 0, cpu_addr = 0.
- Idle latency:
  - cpu_wr at cycle N → cpu_busy = 1 at N+1 → saa_wr_n low at N+2, cpu_busy = 0 at N+2.
  - Stream handshake at cycle N → saa_wr_n low at N+1.
- Each phase lasts WR_LOW + WR_HIGH cycles.
  - Full pair, defaults: 8 cycles of bus activity.
  - Skipped-address pair: 4 cycles.
- Back-to-back transactions: IDLE lasts exactly 1 cycle when a request is pending. saa_wr_n is never low in two adjacent phases without ≥ WR_HIGH high cycles.
- Reset mid-transaction: the next cycle has saa_wr_n = saa_cs_n = 1, the transaction is abandoned, and the slot is emptied. No further falling edge occurs.
- A simultaneous cpu_wr and slot grant in IDLE is accepted (slot frees the same cycle) and does not set cpu_ovf.

## Structure
- Package saa1099_ctl_pkg:
  - state enum: IDLE, ADDR_LO, ADDR_HI, DATA_LO, DATA_HI.
  - typedef cpu_req_t {a0, data[7:0]}.
  - typedef stream_req_t {reg[4:0], data[7:0]}.
  - SAA register address constants 0x18, 0x19, 0x1C.
- One sub-module, saa1099_wr_strobe:
  - start → LO/HI timing counter ($clog2 of max(WR_LOW, WR_HIGH)).
  - Outputs strobe level and done.
  - Instantiated once, shared by all phases.

## Test plan
- CPU addr 0x1C, then CPU data 0x01: two ADDR/DATA bus cycles.
  - saa_a0 = 1 with din 0x1C, then saa_a0 = 0 with din 0x01.
  - First wr_n falling edge at N+2; each low for 2 cycles.
- CPU addr 0x05; stream pair (0x08, 0x40); CPU data 0x77:
  - Bus sequence: A05, A08, D40, A05 (restore), D77.
- Stream pairs (0x08, 0x10) then (0x08, 0x20) back-to-back: second pair skips ADDR.
  - Bus sequence: A08, D10, D20.
  - fifo_ready high only in IDLE cycles.
- CPU and stream both pending continuously:
  - Grants alternate, CPU first after reset.
  - No requester waits more than one transaction.
- Two cpu_wr two cycles apart during an active transaction:
  - First is captured; second is dropped; cpu_ovf = 1 and stays set until rst.
- rst asserted during ADDR_LO:
  - Next cycle saa_wr_n = saa_cs_n = 1, active = 0.
  - The following stream pair issues an ADDR write (chip_addr_ok = 0).

Source files
------------

// File: rtl/saa1099_ctl_pkg.sv
// rtl/saa1099_ctl_pkg.sv - shared types and register constants for the SAA1099 write-port arbiter
package saa1099_ctl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR_LO,
        ADDR_HI,
        DATA_LO,
        DATA_HI
    } state_t;

    typedef struct packed {
        logic       a0;
        logic [7:0] data;
    } cpu_req_t;

    typedef struct packed {
        logic [4:0] reg_addr;
        logic [7:0] data;
    } stream_req_t;

    localparam logic [4:0] SAA_REG_ENV0   = 5'h18;
    localparam logic [4:0] SAA_REG_ENV1   = 5'h19;
    localparam logic [4:0] SAA_REG_SND_EN = 5'h1C;

endpackage

// File: rtl/saa1099_wr_strobe.sv
// rtl/saa1099_wr_strobe.sv - low/high segment timer for one SAA1099 bus phase
module saa1099_wr_strobe #(
    parameter int WR_LOW  = 2,
    parameter int WR_HIGH = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_start,
    output logic o_strobe,
    output logic o_done
);
    localparam int MAXC = (WR_LOW > WR_HIGH) ? WR_LOW : WR_HIGH;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] LO_LAST = CW'(WR_LOW - 1);
    localparam logic [CW-1:0] HI_LAST = CW'(WR_HIGH - 1);

    logic [CW-1:0] r_cnt;
    logic          r_busy;
    logic          r_lo;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_lo   <= 1'b0;
        end else if (i_start) begin
            r_cnt  <= '0;
            r_busy <= 1'b1;
            r_lo   <= 1'b1;
        end else if (r_busy) begin
            if (r_lo) begin
                if (r_cnt == LO_LAST) begin
                    r_lo  <= 1'b0;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else if (r_cnt == HI_LAST) begin
                r_busy <= 1'b0;
                r_cnt  <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // done marks the last cycle of whichever segment is running; strobe says which one
    assign o_strobe = r_busy & r_lo;
    assign o_done   = r_busy & (r_lo ? (r_cnt == LO_LAST) : (r_cnt == HI_LAST));

endmodule

// File: rtl/saa1099_bus_arbiter.sv
// rtl/saa1099_bus_arbiter.sv - serialises CPU and register-stream writes onto the SAA1099 bus
module saa1099_bus_arbiter #(
    parameter int WR_LOW  = 2,
    parameter int WR_HIGH = 2
) (
    input  logic       clk_sys,
    input  logic       rst,
    input  logic       cpu_wr,
    input  logic       cpu_a0,
    input  logic [7:0] cpu_din,
    output logic       cpu_busy,
    output logic       cpu_ovf,
    input  logic       fifo_valid,
    input  logic [4:0] fifo_reg,
    input  logic [7:0] fifo_data,
    output logic       fifo_ready,
    output logic       saa_cs_n,
    output logic       saa_wr_n,
    output logic       saa_a0,
    output logic [7:0] saa_din,
    output logic       active
);
    import saa1099_ctl_pkg::*;

    state_t      r_state;
    cpu_req_t    r_slot;
    logic        r_slot_full;
    logic        r_ovf;
    logic [4:0]  r_cpu_addr;
    logic [4:0]  r_chip_addr;
    logic        r_chip_ok;
    logic        r_last_cpu;
    logic [4:0]  r_txn_addr;
    logic [7:0]  r_txn_data;
    logic        r_txn_has_data;
    logic        r_fifo_ready;
    logic        r_cs_n;
    logic        r_wr_n;
    logic        r_a0;
    logic [7:0]  r_din;
    logic        r_active;

    state_t      w_next;
    stream_req_t w_stream;
    logic        w_idle;
    logic        w_grant_fifo;
    logic        w_grant_cpu;
    logic [7:0]  w_g_addr;
    logic [7:0]  w_g_data;
    logic        w_g_has_data;
    logic        w_g_need_addr;
    logic        w_start;
    logic        w_strobe;
    logic        w_seg_done;
    logic        w_lo_end;
    logic        w_hi_end;
    logic        w_cpu_accept;
    logic        w_slot_full_next;
    logic        w_last_cpu_next;

    saa1099_wr_strobe #(
        .WR_LOW  (WR_LOW),
        .WR_HIGH (WR_HIGH)
    ) u_strobe (
        .i_clk    (clk_sys),
        .i_rst    (rst),
        .i_start  (w_start),
        .o_strobe (w_strobe),
        .o_done   (w_seg_done)
    );

    assign w_stream     = '{reg_addr: fifo_reg, data: fifo_data};
    assign w_idle       = (r_state == IDLE);
    assign w_lo_end     = w_seg_done & w_strobe;
    assign w_hi_end     = w_seg_done & ~w_strobe;
    // registered fifo_ready already encodes the round-robin choice
    assign w_grant_fifo = w_idle & r_fifo_ready & fifo_valid;
    assign w_grant_cpu  = w_idle & r_slot_full & ~w_grant_fifo;

    assign w_cpu_accept     = cpu_wr & (~r_slot_full | w_grant_cpu);
    assign w_slot_full_next = w_cpu_accept | (r_slot_full & ~w_grant_cpu);
    assign w_last_cpu_next  = w_grant_cpu | (r_last_cpu & ~w_grant_fifo);

    always_comb begin
        w_g_addr     = {3'b000, r_cpu_addr};
        w_g_data     = r_slot.data;
        w_g_has_data = 1'b1;
        if (w_grant_fifo) begin
            w_g_addr = {3'b000, w_stream.reg_addr};
            w_g_data = w_stream.data;
        end else if (r_slot.a0) begin
            w_g_addr     = r_slot.data;
            w_g_has_data = 1'b0;
        end
        w_g_need_addr = ~w_g_has_data | ~r_chip_ok | (r_chip_addr != w_g_addr[4:0]);
    end

    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_grant_fifo | w_grant_cpu) begin
                    w_next  = w_g_need_addr ? ADDR_LO : DATA_LO;
                    w_start = 1'b1;
                end
            end
            ADDR_LO: if (w_lo_end) w_next = ADDR_HI;
            ADDR_HI: begin
                if (w_hi_end) begin
                    w_next  = r_txn_has_data ? DATA_LO : IDLE;
                    w_start = r_txn_has_data;
                end
            end
            DATA_LO: if (w_lo_end) w_next = DATA_HI;
            DATA_HI: if (w_hi_end) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            r_slot         <= '0;
            r_slot_full    <= 1'b0;
            r_ovf          <= 1'b0;
            r_cpu_addr     <= '0;
            r_chip_addr    <= '0;
            r_chip_ok      <= 1'b0;
            r_last_cpu     <= 1'b0;
            r_txn_addr     <= '0;
            r_txn_data     <= '0;
            r_txn_has_data <= 1'b0;
            r_fifo_ready   <= 1'b0;
            r_cs_n         <= 1'b1;
            r_wr_n         <= 1'b1;
            r_a0           <= 1'b0;
            r_din          <= '0;
            r_active       <= 1'b0;
        end else begin
            r_slot_full <= w_slot_full_next;
            r_last_cpu  <= w_last_cpu_next;
            if (w_cpu_accept) begin
                r_slot <= '{a0: cpu_a0, data: cpu_din};
                if (cpu_a0) r_cpu_addr <= cpu_din[4:0];
            end
            if (cpu_wr & ~w_cpu_accept) r_ovf <= 1'b1;
            if (w_grant_fifo | w_grant_cpu) begin
                r_txn_addr     <= w_g_addr[4:0];
                r_txn_data     <= w_g_data;
                r_txn_has_data <= w_g_has_data;
            end
            if ((r_state == ADDR_HI) && w_hi_end) begin
                r_chip_addr <= r_txn_addr;
                r_chip_ok   <= 1'b1;
            end
            r_fifo_ready <= (w_next == IDLE) & (~w_slot_full_next | w_last_cpu_next);
            r_active     <= (w_next != IDLE);
            r_wr_n       <= ~((w_next == ADDR_LO) | (w_next == DATA_LO));
            r_cs_n       <= ~((w_next == ADDR_LO) | (w_next == DATA_LO));
            // a0/din are loaded once per phase so they stay put across LO and HI
            if (w_start) begin
                if (w_next == ADDR_LO) begin
                    r_a0  <= 1'b1;
                    r_din <= w_g_addr;
                end else begin
                    r_a0  <= 1'b0;
                    r_din <= w_idle ? w_g_data : r_txn_data;
                end
            end
        end
    end

    assign cpu_busy   = r_slot_full;
    assign cpu_ovf    = r_ovf;
    assign fifo_ready = r_fifo_ready;
    assign saa_cs_n   = r_cs_n;
    assign saa_wr_n   = r_wr_n;
    assign saa_a0     = r_a0;
    assign saa_din    = r_din;
    assign active     = r_active;

endmodule

// File: tb/tb_saa1099_bus_arbiter.sv
// tb/tb_saa1099_bus_arbiter.sv - self-checking bench with a transaction-level reference model
module tb_saa1099_bus_arbiter;
    import saa1099_ctl_pkg::*;

    localparam int WR_LOW  = 2;
    localparam int WR_HIGH = 2;
    localparam int PH      = WR_LOW + WR_HIGH;

    logic       clk_sys = 1'b0;
    logic       rst = 1'b1;
    logic       cpu_wr = 1'b0;
    logic       cpu_a0 = 1'b0;
    logic [7:0] cpu_din = '0;
    logic       cpu_busy;
    logic       cpu_ovf;
    logic       fifo_valid = 1'b0;
    logic [4:0] fifo_reg = '0;
    logic [7:0] fifo_data = '0;
    logic       fifo_ready;
    logic       saa_cs_n;
    logic       saa_wr_n;
    logic       saa_a0;
    logic [7:0] saa_din;
    logic       active;

    always #5 clk_sys = ~clk_sys;

    saa1099_bus_arbiter #(.WR_LOW(WR_LOW), .WR_HIGH(WR_HIGH)) dut (
        .clk_sys    (clk_sys),
        .rst        (rst),
        .cpu_wr     (cpu_wr),
        .cpu_a0     (cpu_a0),
        .cpu_din    (cpu_din),
        .cpu_busy   (cpu_busy),
        .cpu_ovf    (cpu_ovf),
        .fifo_valid (fifo_valid),
        .fifo_reg   (fifo_reg),
        .fifo_data  (fifo_data),
        .fifo_ready (fifo_ready),
        .saa_cs_n   (saa_cs_n),
        .saa_wr_n   (saa_wr_n),
        .saa_a0     (saa_a0),
        .saa_din    (saa_din),
        .active     (active)
    );

    int n_err = 0;
    int n_chk = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic       a0;
        logic [7:0] din;
        int         due;
    } wr_t;

    wr_t        exp_q[$];
    logic [8:0] log_w[$];
    int         log_c[$];

    // Transaction-level model: each grant books its bus writes and a busy window
    int         cyc = 0;
    int         m_rem = 0;
    int         m_len = 0;
    bit         m_slot_full = 0, m_slot_a0 = 0, m_ovf = 0, m_fr = 0, m_last_cpu = 0, m_ok = 0;
    logic [7:0] m_slot_din = '0;
    logic [4:0] m_chip = '0, m_cpu_addr = '0;

    always @(posedge clk_sys) begin
        bit         g_f, g_c, need, hasd;
        logic [7:0] a, d;
        cyc++;
        if (rst) begin
            m_rem = 0; m_slot_full = 0; m_ovf = 0; m_fr = 0; m_last_cpu = 0; m_ok = 0;
            m_cpu_addr = '0;
            exp_q.delete();
        end else begin
            g_f = (m_rem == 0) && m_fr && fifo_valid;
            g_c = (m_rem == 0) && m_slot_full && !g_f;
            if (g_f || g_c) begin
                if (g_c && m_slot_a0) begin
                    a = m_slot_din; need = 1; hasd = 0;
                end else begin
                    a = g_f ? {3'b000, fifo_reg} : {3'b000, m_cpu_addr};
                    need = !m_ok || (m_chip != a[4:0]);
                    hasd = 1;
                end
                d = g_f ? fifo_data : m_slot_din;
                if (need) exp_q.push_back('{a0: 1'b1, din: a, due: cyc});
                if (hasd) exp_q.push_back('{a0: 1'b0, din: d, due: cyc + (need ? PH : 0)});
                m_len = (need ? PH : 0) + (hasd ? PH : 0);
                m_rem = m_len;
                m_chip = a[4:0];
                m_ok = m_ok || need;
                m_last_cpu = g_c;
            end else if (m_rem > 0) begin
                m_rem--;
            end
            if (cpu_wr) begin
                if (m_slot_full && !g_c) begin
                    m_ovf = 1;
                end else begin
                    m_slot_full = 1; m_slot_a0 = cpu_a0; m_slot_din = cpu_din;
                    if (cpu_a0) m_cpu_addr = cpu_din[4:0];
                end
            end else if (g_c) begin
                m_slot_full = 0;
            end
            m_fr = (m_rem == 0) && (!m_slot_full || m_last_cpu);
        end
    end

    logic prev_wr_n = 1'b1;
    wr_t  cur = '{a0: 1'b0, din: 8'h00, due: 0};

    always @(negedge clk_sys) begin
        bit exp_wr;
        exp_wr = !((m_rem != 0) && (((m_len - m_rem) % PH) < WR_LOW));
        chk("cpu_busy", cpu_busy, m_slot_full);
        chk("cpu_ovf", cpu_ovf, m_ovf);
        chk("fifo_ready", fifo_ready, m_fr);
        chk("active", active, m_rem != 0);
        chk("wr_n", saa_wr_n, exp_wr);
        chk("cs_n", saa_cs_n, exp_wr);
        if (prev_wr_n && !saa_wr_n) begin
            log_w.push_back({saa_a0, saa_din});
            log_c.push_back(cyc);
            chk("write_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                cur = exp_q.pop_front();
                chk("wr_a0", saa_a0, cur.a0);
                chk("wr_din", saa_din, cur.din);
                chk("wr_cycle", cyc, cur.due);
            end
        end
        if (active) begin
            chk("a0_stable", saa_a0, cur.a0);
            chk("din_stable", saa_din, cur.din);
        end
        prev_wr_n = saa_wr_n;
    end

    task automatic cpu_write(input logic a0, input logic [7:0] d);
        cpu_wr = 1'b1; cpu_a0 = a0; cpu_din = d;
        @(negedge clk_sys);
        cpu_wr = 1'b0;
    endtask

    task automatic send_pair(input logic [4:0] r, input logic [7:0] d);
        int n = 0;
        fifo_valid = 1'b1; fifo_reg = r; fifo_data = d;
        while (!fifo_ready && n < 100) begin
            @(negedge clk_sys);
            n++;
        end
        chk("pair_accept_bound", n < 100, 1);
        @(negedge clk_sys);
        fifo_valid = 1'b0;
    endtask

    task automatic clear_log();
        log_w.delete();
        log_c.delete();
    endtask

    initial begin
        int         t0;
        bit         hs_pend;
        logic [4:0] regs [4];
        regs = '{5'h08, 5'h09, SAA_REG_ENV0, SAA_REG_ENV1};

        repeat (3) @(negedge clk_sys);
        chk("rst_cs_n", saa_cs_n, 1);
        chk("rst_wr_n", saa_wr_n, 1);
        chk("rst_a0", saa_a0, 0);
        chk("rst_din", saa_din, 0);
        chk("rst_busy", cpu_busy, 0);
        chk("rst_ovf", cpu_ovf, 0);
        chk("rst_ready", fifo_ready, 0);
        chk("rst_active", active, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk_sys);

        clear_log();
        t0 = cyc;
        cpu_write(1'b1, {3'b000, SAA_REG_SND_EN});
        cpu_write(1'b0, 8'h01);
        repeat (30) @(negedge clk_sys);
        chk("s1_count", log_w.size(), 2);
        chk("s1_w0", log_w[0], 9'h11C);
        chk("s1_w1", log_w[1], 9'h001);
        chk("s1_latency", log_c[0] - t0, 2);

        clear_log();
        cpu_write(1'b1, 8'h05);
        repeat (3) @(negedge clk_sys);
        send_pair(5'h08, 8'h40);
        cpu_write(1'b0, 8'h77);
        repeat (40) @(negedge clk_sys);
        chk("s2_count", log_w.size(), 5);
        chk("s2_w0", log_w[0], 9'h105);
        chk("s2_w1", log_w[1], 9'h108);
        chk("s2_w2", log_w[2], 9'h040);
        chk("s2_w3", log_w[3], 9'h105);
        chk("s2_w4", log_w[4], 9'h077);

        clear_log();
        send_pair(5'h08, 8'h10);
        send_pair(5'h08, 8'h20);
        repeat (30) @(negedge clk_sys);
        chk("s3_count", log_w.size(), 3);
        chk("s3_w0", log_w[0], 9'h108);
        chk("s3_w1", log_w[1], 9'h010);
        chk("s3_w2", log_w[2], 9'h020);

        send_pair(5'h0A, 8'h33);
        cpu_write(1'b0, 8'h44);
        @(negedge clk_sys);
        cpu_write(1'b0, 8'h55);
        chk("s5_ovf_set", cpu_ovf, 1);
        repeat (40) @(negedge clk_sys);
        chk("s5_ovf_sticky", cpu_ovf, 1);
        rst = 1'b1;
        @(negedge clk_sys);
        rst = 1'b0;
        chk("s5_ovf_cleared", cpu_ovf, 0);
        repeat (3) @(negedge clk_sys);

        send_pair(5'h09, 8'h11);
        rst = 1'b1;
        @(negedge clk_sys);
        rst = 1'b0;
        chk("s6_wr_n", saa_wr_n, 1);
        chk("s6_cs_n", saa_cs_n, 1);
        chk("s6_active", active, 0);
        clear_log();
        repeat (4) @(negedge clk_sys);
        chk("s6_no_edge", log_w.size(), 0);
        send_pair(5'h09, 8'h13);
        repeat (30) @(negedge clk_sys);
        chk("s6_count", log_w.size(), 2);
        chk("s6_w0", log_w[0], 9'h109);
        chk("s6_w1", log_w[1], 9'h013);

        hs_pend = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk_sys);
            if (hs_pend) begin
                fifo_valid = ($urandom % 2) == 0;
                fifo_reg   = regs[$urandom % 4];
                fifo_data  = 8'($urandom);
            end else if (!fifo_valid && ($urandom % 4) == 0) begin
                fifo_valid = 1'b1;
                fifo_reg   = regs[$urandom % 4];
                fifo_data  = 8'($urandom);
            end
            hs_pend = fifo_valid && fifo_ready;
            cpu_wr  = ($urandom % 6) == 0;
            cpu_a0  = 1'($urandom);
            cpu_din = cpu_a0 ? {3'b000, regs[$urandom % 4]} : 8'($urandom);
            rst     = ($urandom % 400) == 0;
        end
        @(negedge clk_sys);
        fifo_valid = 1'b0;
        cpu_wr = 1'b0;
        rst = 1'b0;
        repeat (40) @(negedge clk_sys);
        chk("exp_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
